// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with a three-state IDLE/FETCH/EXEC FSM.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   run                   - fetch enable; low parks the unit in IDLE
//   imem_req/imem_addr    - instruction-memory read request; address is pc
//   imem_ack/imem_rdata   - read data valid strobe and instruction word
//   instr_valid/instr/op  - instruction register and its opcode, valid in EXEC
//   pc/link_pc            - address of the instruction in IR, and pc+1
//   exec_stall            - datapath holds the current instruction in EXEC
//   sel_PC/jump_target    - absolute jump (highest priority)
//   sum_imm               - taken branch, pc + sext(IR[7:0])
//   stall_cnt             - saturating stall/wait counter (FETCH_STALL_CNT_EN only)
//
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cnt port and counter.

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [4:0]  op,
    output logic [15:0] pc,
    output logic [15:0] link_pc,
    input  logic        exec_stall,
    input  logic        sel_PC,
    input  logic        sum_imm,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    input  logic [15:0] jump_target
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] br_off;

    // Branch offset is a signed 8-bit field; 16-bit add wraps naturally.
    assign br_off = {{8{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                // run is not consulted here: an issued request always completes.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                // pc only moves on the EXEC-exit edge; a stall freezes everything.
                if (!exec_stall) begin
                    state_d = run ? StFetch : StIdle;
                    if (sel_PC) begin
                        pc_d = jump_target;
                    end else if (sum_imm) begin
                        pc_d = pc_q + br_off;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StExec);
    assign instr       = ir_q;
    assign op          = ir_q[15:11];
    assign pc          = pc_q;
    assign link_pc     = pc_q + 16'd1;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_event;

    assign stall_event = ((state_q == StFetch) && !imem_ack) ||
                         ((state_q == StExec) && exec_stall);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit, plus hand-written
// sequences for asynchronous reset during a fetch.

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [4:0]  op;
    logic [15:0] pc;
    logic [15:0] link_pc;
    logic        exec_stall;
    logic        sel_PC;
    logic        sum_imm;
    logic [15:0] jump_target;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fetch_unit #(
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .op         (op),
        .pc         (pc),
        .link_pc    (link_pc),
        .exec_stall (exec_stall),
        .sel_PC     (sel_PC),
        .sum_imm    (sum_imm),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .jump_target(jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        run;
        logic        ack;
        logic [15:0] rdata;
        logic        stall;
        logic        sel;
        logic        sum;
        logic [15:0] jt;
        logic        e_req;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_scnt;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs are applied for one cycle, then outputs after that edge are compared.
        //             run   ack   rdata     stl   sel   sum   jt        req   vld   pc        instr     scnt
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'h0801, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0801, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0801, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 16'h1002, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h1002, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h1002, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 16'h1803, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h1803, 16'd0};
        // three wait states: req held four cycles at addr 0003
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h1803, 16'd0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h1803, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h1803, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h1803, 16'd3};
        vecs[10] = '{1'b1, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h2000, 16'd3};
        // jump beats branch
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h1234, 16'h2000, 16'd3};
        vecs[12] = '{1'b1, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'h3000, 16'd3};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h3000, 16'd3};
        vecs[14] = '{1'b1, 1'b1, 16'h28F8, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h28F8, 16'd3};
        // branch -8 from 0010
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h28F8, 16'd3};
        vecs[16] = '{1'b1, 1'b1, 16'h3801, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h3801, 16'd3};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h3801, 16'd3};
        vecs[18] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'd3};
        // FFFF + 1 wraps to 0000
        vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd3};
        vecs[20] = '{1'b1, 1'b1, 16'h0805, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0805, 16'd3};
        // two stall cycles: jump/branch ignored, everything held
        vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, 16'h0000, 16'h0805, 16'd4};
        vecs[22] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0805, 16'd5};
        vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 16'h0805, 16'd5};
        // stray ack in IDLE ignored
        vecs[24] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 16'h0805, 16'd5};
        vecs[25] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0805, 16'd5};
        // run drops mid-fetch: fetch and exec still complete
        vecs[26] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0805, 16'd6};
        vecs[27] = '{1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h4000, 16'd6};
        vecs[28] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h4000, 16'd6};

        rst_n       = 1'b0;
        run         = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        exec_stall  = 1'b0;
        sel_PC      = 1'b0;
        sum_imm     = 1'b0;
        jump_target = 16'h0000;

        step();
        step();
        check("rst_req",   16'(imem_req),    16'h0000);
        check("rst_valid", 16'(instr_valid), 16'h0000);
        check("rst_pc",    pc,               16'h0000);
        check("rst_instr", instr,            16'h0000);
`ifdef FETCH_STALL_CNT_EN
        check("rst_scnt",  stall_cnt,        16'h0000);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run         = vecs[i].run;
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            exec_stall  = vecs[i].stall;
            sel_PC      = vecs[i].sel;
            sum_imm     = vecs[i].sum;
            jump_target = vecs[i].jt;
            step();
            check($sformatf("v%0d_req", i),   16'(imem_req),    16'(vecs[i].e_req));
            check($sformatf("v%0d_valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
            check($sformatf("v%0d_pc", i),    pc,               vecs[i].e_pc);
            check($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].e_pc);
            check($sformatf("v%0d_instr", i), instr,            vecs[i].e_instr);
            check($sformatf("v%0d_op", i),    16'(op),          16'(vecs[i].e_instr[15:11]));
            check($sformatf("v%0d_link", i),  link_pc,          vecs[i].e_pc + 16'd1);
`ifdef FETCH_STALL_CNT_EN
            check($sformatf("v%0d_scnt", i),  stall_cnt,        vecs[i].e_scnt);
`endif
        end

        // Start a fetch at addr 0002, then reset asynchronously mid-fetch.
        run         = 1'b1;
        imem_ack    = 1'b0;
        exec_stall  = 1'b0;
        sel_PC      = 1'b0;
        sum_imm     = 1'b0;
        step();
        check("mf_req",  16'(imem_req), 16'h0001);
        check("mf_addr", imem_addr,     16'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",   16'(imem_req),    16'h0000);
        check("ar_pc",    pc,               16'h0000);
        check("ar_instr", instr,            16'h0000);
        check("ar_valid", 16'(instr_valid), 16'h0000);
`ifdef FETCH_STALL_CNT_EN
        check("ar_scnt",  stall_cnt,        16'h0000);
`endif
        // Late ack for the dropped request arrives around reset release.
        run        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        step();
        rst_n = 1'b1;
        step();
        check("late_req",   16'(imem_req),    16'h0000);
        check("late_valid", 16'(instr_valid), 16'h0000);
        check("late_instr", instr,            16'h0000);
        check("late_pc",    pc,               16'h0000);

        imem_ack = 1'b0;
        run      = 1'b1;
        step();
        check("restart_req",  16'(imem_req), 16'h0001);
        check("restart_addr", imem_addr,     16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
